// File: rtl/iq_pkg.sv
// Shared constants and FSM encoding for the I/Q interleaver.
package iq_pkg;

    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 4;

    localparam logic [DATA_W-1:0] MIDSCALE = 16'h8000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT_Q = 2'd1,
        EMIT_I = 2'd2
    } iq_state_e;

endpackage

// File: rtl/iq_fifo.sv
// Synchronous FIFO with occupancy count; depth must be a power of two so the
// pointers wrap naturally.
module iq_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             M100CLK,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge M100CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge M100CLK or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/iq_interleaver.sv
// Buffers I/Q pairs and emits them as an offset-binary word stream, Q word
// first then I word, with a one-cycle underflow pulse when the stream starves.
module iq_interleaver
    import iq_pkg::*;
#(
    parameter int DATA_W     = iq_pkg::DATA_W,
    parameter int FIFO_DEPTH = iq_pkg::FIFO_DEPTH,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              M100CLK,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_in,
    input  logic [DATA_W-1:0] q_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              enable,
    output logic [DATA_W-1:0] data_out,
    output logic              phase,
    output logic              out_valid,
    output logic              underflow,
    output logic [LW-1:0]     fifo_level
);

    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

    // Two's complement to offset binary is a flip of the sign bit.
    function automatic logic [DATA_W-1:0] to_offset(input logic [DATA_W-1:0] x);
        return {~x[DATA_W-1], x[DATA_W-2:0]};
    endfunction

    iq_state_e         state, state_n;
    logic [DATA_W-1:0] data_n;
    logic              phase_n;
    logic              valid_n;
    logic              uflow_n;
    logic [DATA_W-1:0] i_hold, i_hold_n;
    logic              pop;
    logic [2*DATA_W-1:0] rd_pair;
    logic              fifo_full;
    logic              fifo_empty;

    iq_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .M100CLK (M100CLK),
        .reset   (reset),
        .push    (in_valid),
        .wr_data ({q_in, i_in}),
        .pop     (pop),
        .rd_data (rd_pair),
        .count   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign in_ready = !fifo_full;

    always_comb begin
        state_n  = state;
        data_n   = MID;
        phase_n  = 1'b0;
        valid_n  = 1'b0;
        uflow_n  = 1'b0;
        i_hold_n = i_hold;
        pop      = 1'b0;
        case (state)
            IDLE, EMIT_I: begin
                if (enable && !fifo_empty) begin
                    pop      = 1'b1;
                    data_n   = to_offset(rd_pair[2*DATA_W-1:DATA_W]);
                    valid_n  = 1'b1;
                    i_hold_n = rd_pair[DATA_W-1:0];
                    state_n  = EMIT_Q;
                end else begin
                    // Starving mid-stream is an underflow; stopping on request is not.
                    uflow_n = (state == EMIT_I) && enable;
                    state_n = IDLE;
                end
            end
            EMIT_Q: begin
                data_n  = to_offset(i_hold);
                phase_n = 1'b1;
                valid_n = 1'b1;
                state_n = EMIT_I;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge M100CLK or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            data_out  <= MID;
            phase     <= 1'b0;
            out_valid <= 1'b0;
            underflow <= 1'b0;
            i_hold    <= '0;
        end else begin
            state     <= state_n;
            data_out  <= data_n;
            phase     <= phase_n;
            out_valid <= valid_n;
            underflow <= uflow_n;
            i_hold    <= i_hold_n;
        end
    end

endmodule
